alu_mdu: RTL

//  Parametrised, registered successor of the single-cycle MIPS ALU. Keeps the ALUFun op encoding
//  (add/sub, logic, shift, compare) at WIDTH bits and adds an iterative multiply/divide unit.
//  The multiply/divide unit writes HI/LO. Sits in EX stage; valid/ready handshake lets the pipeline stall on MUL/DIV.

---
 rtl/alu_mdu.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// +--------------------------------------------------------------------------+
// | alu_mdu : registered ALU with iterative multiply/divide unit (HI/LO)     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  input  logic [1:0]       MDOp,
  input  logic             Sign,
  output logic             out_valid,
  output logic [WIDTH-1:0] Z,
  output logic             V,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             md_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  state_t             state;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   dividend;
  logic               neg_main;
  logic               neg_rem;
  logic               div_zero;

  logic               is_sub;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   sum;
  logic               alu_ovf;
  logic               a_neg;
  logic               a_zero;
  logic               a_eq_b;
  logic               a_lt_b;
  logic [SHW-1:0]     shamt;
  logic               cmp_bit;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;

  assign is_sub  = ALUFun[0];
  assign b_eff   = is_sub ? ~B : B;
  assign sum     = A + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
  assign alu_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
  assign a_neg   = A[WIDTH-1];
  assign a_zero  = (A == '0);
  assign a_eq_b  = (A == B);
  assign a_lt_b  = Sign ? ($signed(A) < $signed(B)) : (A < B);
  assign shamt   = A[SHW-1:0];
  assign alu_v   = (ALUFun[5:4] == 2'b00) && Sign && alu_ovf;

  always_comb begin
    cmp_bit = 1'b0;
    case (ALUFun[3:1])
      3'b001:  cmp_bit = a_eq_b;
      3'b000:  cmp_bit = ~a_eq_b;
      3'b010:  cmp_bit = a_lt_b;
      3'b110:  cmp_bit = a_neg | a_zero;
      3'b101:  cmp_bit = a_neg;
      3'b111:  cmp_bit = ~a_neg & ~a_zero;
      default: cmp_bit = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (ALUFun[5:4])
      2'b00: alu_res = sum;
      2'b01: begin
        case (ALUFun[3:0])
          4'b1000: alu_res = A & B;
          4'b1110: alu_res = A | B;
          4'b0110: alu_res = A ^ B;
          4'b0001: alu_res = ~(A | B);
          4'b1010: alu_res = A;
          default: alu_res = '0;
        endcase
      end
      2'b10: begin
        case (ALUFun[1:0])
          2'b00:   alu_res = B << shamt;
          2'b01:   alu_res = B >> shamt;
          2'b11:   alu_res = $unsigned($signed(B) >>> shamt);
          default: alu_res = '0;
        endcase
      end
      default: alu_res = {{(WIDTH-1){1'b0}}, cmp_bit};
    endcase
  end

  // Signed MD ops run on magnitudes; the sign is reapplied when the result is written.
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;

  assign a_mag    = (Sign && A[WIDTH-1]) ? -A : A;
  assign b_mag    = (Sign && B[WIDTH-1]) ? -B : B;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign mul_res  = neg_main ? -mul_next : mul_next;

  // Restoring step: a set top bit of the difference means the trial subtract borrowed.
  assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd};
  assign div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign quo      = div_next[WIDTH-1:0];
  assign rem      = div_next[2*WIDTH-1:WIDTH];
  assign quo_res  = div_zero ? '1 : (neg_main ? -quo : quo);
  assign rem_res  = div_zero ? dividend : (neg_rem ? -rem : rem);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      dividend  <= '0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
      Z         <= '0;
      V         <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      md_busy   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (MDOp == 2'b01 || MDOp == 2'b10) begin
              state    <= (MDOp == 2'b01) ? ST_MULT : ST_DIV;
              cnt      <= '0;
              acc      <= {{WIDTH{1'b0}}, (MDOp == 2'b01) ? b_mag : a_mag};
              opnd     <= (MDOp == 2'b01) ? a_mag : b_mag;
              dividend <= A;
              neg_main <= Sign && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_rem  <= Sign && A[WIDTH-1];
              div_zero <= (MDOp == 2'b10) && (B == '0);
              in_ready <= 1'b0;
              md_busy  <= 1'b1;
            end else begin
              Z         <= alu_res;
              V         <= alu_v;
              out_valid <= 1'b1;
            end
          end
        end
        ST_MULT: begin
          acc <= mul_next;
          cnt <= cnt + SHW'(1);
          if (cnt == LAST_ITER) begin
            HI        <= mul_res[2*WIDTH-1:WIDTH];
            LO        <= mul_res[WIDTH-1:0];
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DIV: begin
          acc <= div_next;
          cnt <= cnt + SHW'(1);
          if (cnt == LAST_ITER) begin
            HI        <= rem_res;
            LO        <= quo_res;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          md_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
